// File: rtl/axis_be_skid_stage.sv
// Registered AXI-Stream slice with a two-entry skid buffer for the big-endian stream.
// Keeps packet statistics and, with STRB_CHECK_EN defined, checks tstrb legality.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   s_axis_*                upstream big-endian stream (tready is a register output)
//   m_axis_*                registered downstream stream
//   clear_stats             synchronous clear of pkt_count, err_count, err_sticky
//   pkt_count               saturating count of accepted tlast beats
//   err_count, err_sticky   illegal-tstrb statistics (constant 0 without STRB_CHECK_EN)
module axis_be_skid_stage #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            clear_stats,
  output logic [C_CNT_WIDTH-1:0]          pkt_count,
  output logic [C_CNT_WIDTH-1:0]          err_count,
  output logic                            err_sticky
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int BW = DW + SW + UW + 1;

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [BW-1:0]   main_q;
  logic [BW-1:0]   main_d;
  logic [BW-1:0]   skid_q;
  logic [BW-1:0]   skid_d;
  logic            s_ready_q;
  logic            s_ready_d;
  logic [BW-1:0]   in_beat;
  logic            m_valid;
  logic            acc;
  logic            drn;

  // ---------------------------------------------------------------
  // Handshake events
  // ---------------------------------------------------------------
  assign in_beat = {s_axis_tdata, s_axis_tstrb,
                    s_axis_tuser, s_axis_tlast};

  assign m_valid = (state_q != EMPTY);
  assign acc     = s_axis_tvalid & s_ready_q;
  assign drn     = m_valid & m_axis_tready;

  // ---------------------------------------------------------------
  // Buffer control
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = in_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          (acc & drn): begin
            main_d = in_beat;
          end
          (acc & ~drn): begin
            skid_d  = in_beat;
            state_d = TWO;
          end
          (~acc & drn): begin
            state_d = EMPTY;
          end
          default: begin
            state_d = ONE;
          end
        endcase
      end
      TWO: begin
        if (drn) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Ready is registered from the next state so that it never
  // depends combinationally on m_axis_tready.
  always_comb begin
    s_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid;

  assign {m_axis_tdata, m_axis_tstrb,
          m_axis_tuser, m_axis_tlast} = main_q;

  // ---------------------------------------------------------------
  // Packet statistics
  // ---------------------------------------------------------------
  logic [C_CNT_WIDTH-1:0] pkt_q;
  logic [C_CNT_WIDTH-1:0] pkt_d;

  always_comb begin
    pkt_d = pkt_q;
    if (clear_stats) begin
      pkt_d = '0;
    end else if (acc & s_axis_tlast & ~(&pkt_q)) begin
      pkt_d = pkt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_count = pkt_q;

`ifdef STRB_CHECK_EN
  // ---------------------------------------------------------------
  // tstrb legality for big-endian ordering
  // ---------------------------------------------------------------
  logic                   strb_full;
  logic                   strb_hole;
  logic                   strb_last_ok;
  logic                   strb_bad;
  logic [C_CNT_WIDTH-1:0] err_q;
  logic [C_CNT_WIDTH-1:0] err_d;
  logic                   sticky_q;
  logic                   sticky_d;

  // A last beat must look like 1..10..0: the MSB is set and no
  // lower bit is set below a cleared one.
  always_comb begin
    strb_full    = &s_axis_tstrb;
    strb_hole    = |(s_axis_tstrb[SW-2:0] & ~s_axis_tstrb[SW-1:1]);
    strb_last_ok = s_axis_tstrb[SW-1] & ~strb_hole;
    strb_bad     = acc & (s_axis_tlast ? ~strb_last_ok : ~strb_full);
  end

  always_comb begin
    err_d    = err_q;
    sticky_d = sticky_q;
    if (clear_stats) begin
      err_d    = '0;
      sticky_d = 1'b0;
    end else if (strb_bad) begin
      sticky_d = 1'b1;
      if (~(&err_q)) begin
        err_d = err_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign err_count  = err_q;
  assign err_sticky = sticky_q;
`else
  assign err_count  = '0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_axis_be_skid_stage.sv
// Self-checking bench for axis_be_skid_stage.
// Compares the DUT against a queue-based occupancy and statistics model.
module tb_axis_be_skid_stage;

  localparam int DW   = 128;
  localparam int SW   = DW / 8;
  localparam int UW   = 16;
  localparam int CW   = 8;
  localparam int BW   = DW + SW + UW + 1;
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [BW-1:0] beat_t;

  logic          clk;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          clear_stats;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] err_count;
  logic          err_sticky;

  axis_be_skid_stage #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .C_CNT_WIDTH       (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tstrb (s_axis_tstrb),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .clear_stats  (clear_stats),
    .pkt_count    (pkt_count),
    .err_count    (err_count),
    .err_sticky   (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: in-flight beats in arrival order plus counters.
  beat_t q[$];
  int    exp_pkt;
  int    exp_err;
  bit    exp_sticky;
  bit    exp_rdy;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Legal big-endian tstrb: all ones mid-packet; on the last beat
  // the k leading bytes (k >= 1) are enabled and nothing else.
  function automatic bit strb_legal(input logic [SW-1:0] s,
                                    input logic last);
    logic [SW-1:0] m;
    if (!last) return (s == {SW{1'b1}});
    for (int k = 1; k <= SW; k++) begin
      m = {SW{1'b1}};
      m = m << (SW - k);
      if (s == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outputs();
    chk("m_tvalid", m_axis_tvalid, q.size() != 0);
    chk("s_tready", s_axis_tready, exp_rdy);
    if (q.size() != 0)
      chk("m_beat", {m_axis_tdata, m_axis_tstrb,
                     m_axis_tuser, m_axis_tlast}, q[0]);
    chk("pkt_count", pkt_count, exp_pkt);
    chk("err_count", err_count, exp_err);
    chk("err_sticky", err_sticky, exp_sticky);
  endtask

  // One clock: check, then advance the model by what the edge does.
  task automatic cycle(output bit acc);
    bit    drn;
    bit    clr;
    bit    rst;
    beat_t b;
    check_outputs();
    rst = reset;
    clr = clear_stats;
    acc = s_axis_tvalid & exp_rdy & !rst;
    drn = (q.size() != 0) & m_axis_tready & !rst;
    b   = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      exp_rdy    = 1'b0;
      exp_pkt    = 0;
      exp_err    = 0;
      exp_sticky = 1'b0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(b);
      if (clr) begin
        exp_pkt    = 0;
        exp_err    = 0;
        exp_sticky = 1'b0;
      end else if (acc) begin
        if (b[0] && exp_pkt < CMAX) exp_pkt++;
`ifdef STRB_CHECK_EN
        if (!strb_legal(b[UW+1 +: SW], b[0])) begin
          if (exp_err < CMAX) exp_err++;
          exp_sticky = 1'b1;
        end
`endif
      end
      exp_rdy = (q.size() < 2);
    end
  endtask

  task automatic tick();
    bit a;
    cycle(a);
  endtask

  task automatic drive(input bit v, input bit last,
                       input logic [SW-1:0] strb);
    s_axis_tvalid = v;
    s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tuser  = UW'($urandom);
    s_axis_tlast  = last;
    s_axis_tstrb  = strb;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input bit last, input logic [SW-1:0] strb);
    bit a;
    int n;
    drive(1'b1, last, strb);
    n = 0;
    do begin
      cycle(a);
      n++;
    end while (!a && n < 200);
    if (!a) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_timeout observed=stuck expected=accept");
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) tick();
  endtask

  function automatic logic [SW-1:0] rand_strb(input bit last);
    logic [SW-1:0] s;
    int k;
    if ($urandom_range(0, 9) == 0) return SW'($urandom);
    s = {SW{1'b1}};
    if (last) begin
      k = $urandom_range(1, SW);
      s = s << (SW - k);
    end
    return s;
  endfunction

  initial begin
    bit a;
    int acc_in_stall;
    int sent;
    int cyc;
    int bcnt;
    bit pending;
    bit exp_st;

    reset         = 1'b1;
    clear_stats   = 1'b0;
    m_axis_tready = 1'b0;
    drive(1'b0, 1'b0, '0);
    q.delete();
    exp_rdy    = 1'b0;
    exp_pkt    = 0;
    exp_err    = 0;
    exp_sticky = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    tick();
    tick();
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tstrb", m_axis_tstrb, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tready", s_axis_tready, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", s_axis_tready, 1);

    // 4-beat packet, downstream always ready.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(i == 3, {SW{1'b1}});
    drain();
    chk("pkt1_count", pkt_count, 1);

    // Continuous input with a 3-cycle downstream stall.
    acc_in_stall = 0;
    bcnt = 0;
    drive(1'b1, 1'b0, {SW{1'b1}});
    for (int c = 0; c < 12; c++) begin
      m_axis_tready = !(c >= 3 && c <= 5);
      cycle(a);
      if (a && c >= 3 && c <= 5) acc_in_stall++;
      if (a) begin
        bcnt++;
        drive(1'b1, (bcnt % 4) == 3, {SW{1'b1}});
      end
    end
    chk("stall_extra_beats", acc_in_stall, 1);
    drain();

    // Randomized traffic, 1000 beats.
    sent    = 0;
    cyc     = 0;
    pending = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (!pending && $urandom_range(0, 2) != 0) begin
        bit l;
        l = ($urandom_range(0, 3) == 0);
        drive(1'b1, l, rand_strb(l));
        pending = 1'b1;
      end
      s_axis_tvalid = pending;
      m_axis_tready = ($urandom_range(0, 3) != 0);
      clear_stats   = ($urandom_range(0, 19) == 0);
      cycle(a);
      cyc++;
      if (a) begin
        pending = 1'b0;
        sent++;
      end
    end
    clear_stats = 1'b0;
    if (sent < 1000) begin
      n_checks++;
      n_errors++;
      $error("FAIL random_budget observed=%0d expected=1000", sent);
    end
    drain();

    // tstrb legality on last beats.
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    send(1'b1, 16'h0007);
    drain();
`ifdef STRB_CHECK_EN
    exp_st = 1'b1;
`else
    exp_st = 1'b0;
`endif
    chk("strb_0007_sticky", err_sticky, exp_st);
    chk("strb_0007_count", err_count, exp_st);
    send(1'b1, 16'hC000);
    drain();
    chk("strb_c000_count", err_count, exp_st);

    // Clear coinciding with a tlast acceptance.
    clear_stats = 1'b1;
    send(1'b1, {SW{1'b1}});
    clear_stats = 1'b0;
    tick();
    chk("clear_wins", pkt_count, 0);
    drain();

    // Saturation of both counters.
    for (int i = 0; i < CMAX + 5; i++) send(1'b1, 16'h0001);
    drain();
    chk("pkt_saturate", pkt_count, CMAX);

    // Reset while both entries are full.
    m_axis_tready = 1'b0;
    send(1'b0, {SW{1'b1}});
    send(1'b1, {SW{1'b1}});
    drive(1'b1, 1'b0, {SW{1'b1}});
    tick();
    chk("two_tready", s_axis_tready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("rst_two_tvalid", m_axis_tvalid, 0);
    chk("rst_two_pkt", pkt_count, 0);
    chk("rst_two_err", err_count, 0);
    tick();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) send(i == 2, {SW{1'b1}});
    drain();
    chk("post_rst_pkt", pkt_count, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
